// File: rtl/lif_core_pkg.sv
// Shared constants for the output-layer LIF engine: default geometry, Q12 neuron
// constants and FSM state encodings.
package lif_core_pkg;

  localparam int M_DEF       = 784;
  localparam int N_DEF       = 8;
  localparam int W_DEF       = 24;
  localparam int T_STEPS_DEF = 32;
  localparam int D_DEF       = 614;
  localparam int TH_DEF      = 15018;
  localparam int REF_DEF     = 30;
  localparam int PRES_DEF    = 0;
  localparam int PMIN_DEF    = -2048000;

  typedef logic [1:0] lif_state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane potential, refractory counter,
// saturating accumulate during ACC and clamp/leak/threshold during FIRE.
module lif_neuron
  import lif_core_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int D    = D_DEF,
  parameter int TH   = TH_DEF,
  parameter int REF  = REF_DEF,
  parameter int PRES = PRES_DEF,
  parameter int PMIN = PMIN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         acc_en,
  input  logic         fire,
  input  logic [W-1:0] wgt,
  output logic         spike
);

  localparam int RW = (REF > 0) ? $clog2(REF + 1) : 1;

  localparam logic signed [W-1:0] SMAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] D_Q    = W'(D);
  localparam logic signed [W-1:0] TH_Q   = W'(TH);
  localparam logic signed [W-1:0] PRES_Q = W'(PRES);
  localparam logic signed [W-1:0] PMIN_Q = W'(PMIN);
  localparam logic [RW-1:0]       REF_Q  = RW'(REF);

  logic signed [W-1:0] pot;
  logic signed [W-1:0] p_sat;
  logic signed [W-1:0] p_clamp;
  logic signed [W-1:0] p_step;
  logic signed [W-1:0] p_leak;
  logic [RW-1:0]       ref_cnt;
  logic [W:0]          sum;

  // One extra bit exposes signed overflow: the top two bits disagree.
  assign sum = {pot[W-1], pot} + {wgt[W-1], wgt};

  always_comb begin
    p_sat = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      p_sat = sum[W] ? SMIN : SMAX;
    end

    p_clamp = (pot < PMIN_Q) ? PMIN_Q : pot;
    p_step  = p_clamp;
    p_leak  = p_clamp;
    if (p_clamp > PRES_Q) begin
      p_step = p_clamp - D_Q;
      p_leak = (p_step > PRES_Q) ? p_step : PRES_Q;
    end else if (p_clamp < PRES_Q) begin
      p_step = p_clamp + D_Q;
      p_leak = (p_step < PRES_Q) ? p_step : PRES_Q;
    end

    spike = (ref_cnt == '0) && (p_leak >= TH_Q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pot     <= PRES_Q;
      ref_cnt <= '0;
    end else if (clr) begin
      pot     <= PRES_Q;
      ref_cnt <= '0;
    end else if (fire) begin
      if (ref_cnt != '0) begin
        pot     <= PRES_Q;
        ref_cnt <= ref_cnt - 1'b1;
      end else if (spike) begin
        pot     <= PRES_Q;
        ref_cnt <= REF_Q;
      end else begin
        pot <= p_leak;
      end
    end else if (acc_en && (ref_cnt == '0)) begin
      pot <= p_sat;
    end
  end

endmodule

// File: rtl/lif_core.sv
// Output-layer LIF engine: streams M pixel spikes/weights per time unit into N
// neurons and emits one spike vector with a TU_incre strobe per time unit.
//
// state  | meaning
// IDLE   | waiting for start_img; also the one cycle after the last strobe
// ACC    | addr_cnt 0..M, integrating spike_in/wgt_in of the previous address
// FIRE   | clamp/leak/threshold in every neuron, register ops, strobe
module lif_core
  import lif_core_pkg::*;
#(
  parameter int M       = M_DEF,
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int T_STEPS = T_STEPS_DEF,
  parameter int D       = D_DEF,
  parameter int TH      = TH_DEF,
  parameter int REF     = REF_DEF,
  parameter int PRES    = PRES_DEF,
  parameter int PMIN    = PMIN_DEF,
  localparam int AW     = (M > 1) ? $clog2(M) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_img,
  output logic [AW-1:0]  pix_addr,
  input  logic           spike_in,
  input  logic [N*W-1:0] wgt_in,
  output logic           coring,
  output logic [N-1:0]   ops,
  output logic           TU_incre,
  output logic           done_core_img
);

  localparam int CW = $clog2(M + 1);
  localparam int TW = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;

  localparam logic [CW-1:0] C_LAST  = CW'(M);
  localparam logic [TW-1:0] TU_LAST = TW'(T_STEPS - 1);

  lif_state_t     state;
  logic [CW-1:0]  addr_cnt;
  logic [TW-1:0]  tu_cnt;
  logic [N-1:0]   spk;
  logic           accept;
  logic           acc_en;
  logic           fire;

  // coring is still high during the final-strobe IDLE cycle, so a held
  // start_img is only taken once coring has actually dropped.
  assign accept   = (state == S_IDLE) && start_img && !coring;
  assign acc_en   = (state == S_ACC) && (addr_cnt != '0) && spike_in;
  assign fire     = (state == S_FIRE);
  assign pix_addr = ((state == S_ACC) && (addr_cnt != C_LAST)) ? addr_cnt[AW-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      addr_cnt      <= '0;
      tu_cnt        <= '0;
      coring        <= 1'b0;
      ops           <= '0;
      TU_incre      <= 1'b0;
      done_core_img <= 1'b0;
    end else begin
      TU_incre      <= 1'b0;
      done_core_img <= 1'b0;
      case (state)
        S_IDLE: begin
          if (coring) begin
            coring <= 1'b0;
          end else if (start_img) begin
            state    <= S_ACC;
            addr_cnt <= '0;
            tu_cnt   <= '0;
            coring   <= 1'b1;
          end
        end
        S_ACC: begin
          if (addr_cnt == C_LAST) begin
            addr_cnt <= '0;
            state    <= S_FIRE;
          end else begin
            addr_cnt <= addr_cnt + 1'b1;
          end
        end
        S_FIRE: begin
          ops      <= spk;
          TU_incre <= 1'b1;
          if (tu_cnt == TU_LAST) begin
            done_core_img <= 1'b1;
            state         <= S_IDLE;
          end else begin
            tu_cnt <= tu_cnt + 1'b1;
            state  <= S_ACC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_neuron
    lif_neuron #(
      .W(W), .D(D), .TH(TH), .REF(REF), .PRES(PRES), .PMIN(PMIN)
    ) u_neuron (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .acc_en(acc_en),
      .fire  (fire),
      .wgt   (wgt_in[j*W +: W]),
      .spike (spk[j])
    );
  end

endmodule

// File: tb/tb_lif_core.sv
// Scoreboard bench for lif_core: an image-level reference model queues the expected
// strobes, per-instance monitors pop and compare whenever TU_incre is seen.
module tb_lif_core;

  localparam int M    = 4;
  localparam int N    = 2;
  localparam int W    = 24;
  localparam int TA   = 3;
  localparam int TB   = 5;
  localparam int REFA = 30;
  localparam int REFB = 2;
  localparam int TPER = M + 2;
  localparam longint LD    = 614;
  localparam longint LTH   = 15018;
  localparam longint LPMIN = -2048000;

  logic           clk;
  logic           rst;
  logic           start_a, start_b;
  logic [1:0]     addr_a, addr_b;
  logic           spike_a, spike_b;
  logic [N*W-1:0] wgt_a, wgt_b;
  logic           coring_a, coring_b;
  logic [N-1:0]   ops_a, ops_b;
  logic           tu_a, tu_b;
  logic           done_a, done_b;

  logic              spk_mem [M];
  logic signed [W-1:0] w_mem [M][N];

  typedef struct {
    logic [N-1:0] ops;
    logic         done;
    int           cyc;
    int           p0;
    int           p1;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   drop_a  = 0;
  bit   drop_b  = 0;

  lif_core #(.M(M), .N(N), .W(W), .T_STEPS(TA), .REF(REFA)) dut_a (
    .clk(clk), .rst(rst), .start_img(start_a), .pix_addr(addr_a),
    .spike_in(spike_a), .wgt_in(wgt_a), .coring(coring_a), .ops(ops_a),
    .TU_incre(tu_a), .done_core_img(done_a)
  );

  lif_core #(.M(M), .N(N), .W(W), .T_STEPS(TB), .REF(REFB)) dut_b (
    .clk(clk), .rst(rst), .start_img(start_b), .pix_addr(addr_b),
    .spike_in(spike_b), .wgt_in(wgt_b), .coring(coring_b), .ops(ops_b),
    .TU_incre(tu_b), .done_core_img(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous spike/weight memories shared by both instances.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    spike_a <= spk_mem[addr_a];
    wgt_a   <= {w_mem[addr_a][1], w_mem[addr_a][0]};
    spike_b <= spk_mem[addr_b];
    wgt_b   <= {w_mem[addr_b][1], w_mem[addr_b][0]};
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  // Whole-image reference: per TU sum the spiking pixels' weights, then apply
  // refractory / floor / leak / threshold exactly as the neuron rules read.
  task automatic model(input bit is_b, input int acc_cyc);
    int     tsteps;
    int     refv;
    longint p [N];
    int     r [N];
    exp_t   e;
    tsteps = is_b ? TB : TA;
    refv   = is_b ? REFB : REFA;
    foreach (p[j]) begin p[j] = 0; r[j] = 0; end
    for (int tu = 0; tu < tsteps; tu++) begin
      for (int j = 0; j < N; j++) begin
        if (r[j] == 0) begin
          for (int i = 0; i < M; i++) begin
            if (spk_mem[i]) p[j] = sat(p[j] + longint'(w_mem[i][j]));
          end
        end
      end
      e.ops = '0;
      for (int j = 0; j < N; j++) begin
        if (r[j] > 0) begin
          p[j] = 0;
          r[j]--;
        end else begin
          if (p[j] < LPMIN) p[j] = LPMIN;
          if (p[j] > 0) p[j] = (p[j] - LD > 0) ? p[j] - LD : 0;
          else if (p[j] < 0) p[j] = (p[j] + LD < 0) ? p[j] + LD : 0;
          if (p[j] >= LTH) begin
            e.ops[j] = 1'b1;
            p[j] = 0;
            r[j] = refv;
          end
        end
      end
      e.done = (tu == tsteps - 1);
      e.cyc  = acc_cyc + (tu + 1) * TPER;
      e.p0   = int'(p[0]);
      e.p1   = int'(p[1]);
      if (is_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (drop_a) begin
      chk("a_coring_drop", coring_a, 0);
      drop_a = 0;
    end
    if (!rst && tu_a) begin
      if (qa.size() == 0) begin
        chk("a_extra_strobe", tu_a, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_ops", ops_a, ea.ops);
        chk("a_done", done_a, ea.done);
        chk("a_strobe_cycle", cyc, ea.cyc);
        chk("a_pot0", dut_a.g_neuron[0].u_neuron.pot, ea.p0);
        chk("a_pot1", dut_a.g_neuron[1].u_neuron.pot, ea.p1);
        chk("a_coring_hi", coring_a, 1);
        if (ea.done) drop_a = 1;
      end
    end else if (!rst && done_a) begin
      chk("a_done_without_strobe", done_a, 0);
    end
  end

  always @(negedge clk) begin
    if (drop_b) begin
      chk("b_coring_drop", coring_b, 0);
      drop_b = 0;
    end
    if (!rst && tu_b) begin
      if (qb.size() == 0) begin
        chk("b_extra_strobe", tu_b, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_ops", ops_b, eb.ops);
        chk("b_done", done_b, eb.done);
        chk("b_strobe_cycle", cyc, eb.cyc);
        chk("b_pot0", dut_b.g_neuron[0].u_neuron.pot, eb.p0);
        chk("b_pot1", dut_b.g_neuron[1].u_neuron.pot, eb.p1);
        chk("b_coring_hi", coring_b, 1);
        if (eb.done) drop_b = 1;
      end
    end else if (!rst && done_b) begin
      chk("b_done_without_strobe", done_b, 0);
    end
  end

  task automatic set_mem(input int spk_mode, input int w0, input int w1);
    for (int i = 0; i < M; i++) begin
      spk_mem[i]  = (spk_mode != 0);
      w_mem[i][0] = W'(w0);
      w_mem[i][1] = W'(w1);
    end
  endtask

  task automatic set_random(input bit big);
    for (int i = 0; i < M; i++) begin
      spk_mem[i] = 1'($urandom_range(0, 1));
      for (int j = 0; j < N; j++) begin
        if (big) w_mem[i][j] = W'($urandom_range(0, 16777215));
        else     w_mem[i][j] = W'(int'($urandom_range(0, 10000)) - 3000);
      end
    end
  endtask

  // Called just after a negedge with the instance idle; returns once every
  // queued strobe has been seen (or the bound expires).
  task automatic run(input bit is_b, input bit hold);
    int k;
    model(is_b, cyc + 1);
    if (is_b) start_b = 1'b1;
    else      start_a = 1'b1;
    @(negedge clk); #1;
    if (is_b) chk("b_coring_rise", coring_b, 1);
    else      chk("a_coring_rise", coring_a, 1);
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    k = 0;
    while (((is_b ? qb.size() : qa.size()) != 0) && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 400) begin
      chk("strobe_timeout", k, 0);
      qa.delete();
      qb.delete();
    end
    if (!hold) repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    set_mem(1, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_coring", coring_a, 0);
    chk("rst_ops", ops_a, 0);
    chk("rst_tu", tu_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_addr", addr_a, 0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    set_mem(1, 4096, 4096);          // fires in TU0 only, refractory after
    run(0, 0);
    set_mem(1, -1000000, -1000000);  // floor then leak, no spikes
    run(0, 0);
    set_mem(1, 8388607, 0);          // saturating sum on neuron 0
    run(0, 0);
    set_mem(0, 4096, 4096);          // no spikes at all
    run(0, 0);

    // Held start_img: one full image, a second accept, then abort mid-ACC.
    set_mem(1, 1500, 1500);
    run(0, 1);
    @(negedge clk); #1;
    k = 0;
    while (!coring_a && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("second_accept", coring_a, 1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_coring", coring_a, 0);
    chk("async_rst_ops", ops_a, 0);
    chk("async_rst_tu", tu_a, 0);
    chk("async_rst_done", done_a, 0);
    chk("async_rst_pot0", dut_a.g_neuron[0].u_neuron.pot, 0);
    start_a = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (4 * TPER) @(negedge clk);
    #1;
    chk("post_rst_idle", coring_a, 0);
    set_mem(1, 4096, 4096);
    run(0, 0);

    set_mem(1, 4096, 4096);          // REF=2: spikes in TU0 and TU3
    run(1, 0);

    for (int n = 0; n < 8; n++) begin
      set_random(n % 4 == 3);
      run(0, 0);
    end
    for (int n = 0; n < 3; n++) begin
      set_random(n == 2);
      run(1, 0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
